// File: rtl/picomips_io_pkg.sv
// Shared types and defaults for the picoMIPS board I/O front end.
// Sequencer states and the common data width live here.
package picomips_io_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    COLLECT = 2'd1,
    SHOW    = 2'd2
  } seq_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser and debouncer.
// Emits a one-cycle press pulse on each accepted rising level.
module btn_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic fastclk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_level_d;
  logic                   r_press;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign level  = r_level;
  assign press  = r_press;

  always_ff @(posedge fastclk) begin
    if (reset) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], btn_raw};
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // count consecutive cycles the synced value disagrees with level
      if (w_sync != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= w_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sw_operand_sequencer.sv
// Switch operand capture, core handshake and LED result stepping.
// Operands go out one per press; results come back and show in turn.
module sw_operand_sequencer
  import picomips_io_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int N_IN         = 2,
  parameter int N_OUT        = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4,
  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1,
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              fastclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_btn,
  output logic [DATA_W-1:0] op_data,
  output logic [IW-1:0]     op_idx,
  output logic              op_valid,
  input  logic              op_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_valid,
  output logic              res_ready,
  output logic [DATA_W-1:0] led,
  output logic [OW-1:0]     disp_idx,
  output logic              busy
);

  localparam logic [IW-1:0] IN_LAST  = IW'(N_IN - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(N_OUT - 1);

  seq_state_e        r_state;
  logic [IW-1:0]     r_in_cnt;
  logic [OW-1:0]     r_out_cnt;
  logic [DATA_W-1:0] r_buf [N_OUT];
  logic [DATA_W-1:0] r_op_data;
  logic [IW-1:0]     r_op_idx;
  logic              r_op_valid;
  logic [DATA_W-1:0] r_led;
  logic [OW-1:0]     r_disp_idx;
  logic              w_level;
  logic              w_press_raw;
  logic              w_press;

  btn_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn (
    .fastclk (fastclk),
    .reset   (reset),
    .btn_raw (sw_btn),
    .level   (w_level),
    .press   (w_press_raw)
  );

  assign w_press   = w_press_raw & w_level;
  assign op_data   = r_op_data;
  assign op_idx    = r_op_idx;
  assign op_valid  = r_op_valid;
  assign led       = r_led;
  assign disp_idx  = r_disp_idx;
  assign busy      = (r_state != CAPTURE);
  assign res_ready = (r_state == COLLECT);

  always_ff @(posedge fastclk) begin
    if (reset) begin
      r_state    <= CAPTURE;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_op_data  <= '0;
      r_op_idx   <= '0;
      r_op_valid <= 1'b0;
      r_led      <= '0;
      r_disp_idx <= '0;
      for (int i = 0; i < N_OUT; i++) r_buf[i] <= '0;
    end else begin
      unique case (r_state)
        CAPTURE: begin
          if (r_op_valid && op_ready) begin
            r_op_valid <= 1'b0;
            if (r_in_cnt == IN_LAST) begin
              r_state   <= COLLECT;
              r_in_cnt  <= '0;
              r_out_cnt <= '0;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end else if (w_press && !r_op_valid) begin
            r_op_data  <= sw_data;
            r_op_idx   <= r_in_cnt;
            r_op_valid <= 1'b1;
          end
        end
        COLLECT: begin
          if (res_valid) begin
            r_buf[r_out_cnt] <= res_data;
            if (r_out_cnt == OUT_LAST) begin
              r_state    <= SHOW;
              r_out_cnt  <= '0;
              r_disp_idx <= '0;
              // with one result, buf[0] is being written this very cycle
              r_led <= (r_out_cnt == '0) ? res_data : r_buf[0];
            end else begin
              r_out_cnt <= r_out_cnt + 1'b1;
            end
          end
        end
        SHOW: begin
          if (w_press) begin
            if (r_disp_idx != OUT_LAST) begin
              r_disp_idx <= r_disp_idx + 1'b1;
              r_led      <= r_buf[r_disp_idx + 1'b1];
            end else begin
              r_state  <= CAPTURE;
              r_in_cnt <= '0;
            end
          end
        end
        default: r_state <= CAPTURE;
      endcase
    end
  end

endmodule
